line_window_3x3: RTL and testbench
==================================

LINE_WINDOW_3X3 -- requirements
Module: line_window_3x3

Interface
REQ-001 SHALL have parameter WIDTH, default 320, frame width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 240, frame height in lines.
REQ-003 SHALL have parameter PIXEL_WIDTH, default 24, bits per pixel.
REQ-004 SHALL have ports, one clock domain, reset asynchronous and active-high:
- clk  in  1  sole clock.
- rst  in  1  asynchronous active-high reset.
- din  in  PIXEL_WIDTH  input pixel, raster order.
- din_valid  in  1  din holds a pixel.
- din_ready  out  1  block accepts din this cycle.
- neighborhood  out  9*PIXEL_WIDTH  flattened 3x3 window; slot k at [k*PIXEL_WIDTH +: PIXEL_WIDTH].
- win_valid  out  1  window and coordinates valid.
- win_ready  in  1  consumer takes the window.
- x_out  out  $clog2(WIDTH)  center column.
- y_out  out  $clog2(HEIGHT)  center row.
- win_last  out  1  window centered at (WIDTH-1, HEIGHT-1).

Function
REQ-005 SHALL accept a pixel on each edge where din_valid and din_ready are both high; SHALL accept no pixel otherwise.
REQ-006 SHALL transfer a window on each edge where win_valid and win_ready are both high; while win_valid is high and win_ready is low, all outputs SHALL hold.
REQ-007 SHALL order window slots row-major around center (x,y): 0=(x-1,y-1), 1=(x,y-1), 2=(x+1,y-1), 3=(x-1,y), 4=(x,y), 5=(x+1,y), 6=(x-1,y+1), 7=(x,y+1), 8=(x+1,y+1).
REQ-008 SHALL output all-zero for any slot outside the frame (x<0, x>=WIDTH, y<0, y>=HEIGHT). Pixels from the opposite row edge SHALL NOT appear in the window.
REQ-009 SHALL store the two previous lines in two WIDTH-deep line buffers plus a 3x3 register window. Input column and row counters SHALL wrap from WIDTH-1 to 0 and from HEIGHT-1 to 0.
REQ-010 SHALL implement states FILL, RUN, FLUSH.
REQ-011 FILL: din_ready=1; the first WIDTH+1 pixels of a frame SHALL be accepted without producing a window; the (WIDTH+1)th acceptance SHALL transition to RUN.
REQ-012 RUN: din_ready = !win_valid || win_ready. Each accepted pixel at raster index i SHALL load the window centered at raster index i-(WIDTH+1); win_valid SHALL be high the cycle after acceptance.
REQ-013 RUN: acceptance of raster index WIDTH*HEIGHT-1 SHALL transition to FLUSH.
REQ-014 FLUSH: din_ready=0. SHALL emit the remaining WIDTH+1 windows, one per free output slot (!win_valid || win_ready), with below-frame slots zeroed.
REQ-015 When the window with win_last=1 transfers, the block SHALL enter FILL with all counters zero, ready for the next frame.
REQ-016 win_last SHALL be high only with the window centered at (WIDTH-1, HEIGHT-1).
REQ-017 Throughput SHALL be one window per cycle when din_valid and win_ready are held high. No pixel SHALL be dropped or duplicated under any valid/ready pattern.
REQ-018 Each frame SHALL produce exactly WIDTH*HEIGHT windows in raster order of center.

Reset
REQ-019 While rst=1, outputs SHALL be: din_ready=0, win_valid=0, win_last=0, neighborhood=0, x_out=0, y_out=0; state SHALL be FILL and all counters 0.
REQ-020 After rst falls, din_ready SHALL be 1 on the first clock edge.
REQ-021 Reset asserted mid-frame SHALL discard all partial state. The next accepted pixel SHALL be treated as raster index 0.
REQ-022 Line buffer contents need no reset; stale contents SHALL never reach the output, because border masking (REQ-008) and FILL cover them.

Verification (WIDTH=4, HEIGHT=3, pixel value = raster index+1)
REQ-023 Continuous stream, win_ready=1 -> first win_valid the cycle after the 6th acceptance; window (0,0) slots 0..8 = 0,0,0,0,1,2,0,5,6.
REQ-024 Same stream -> window (3,2) = 7,8,0,11,12,0,0,0,0 with win_last=1; exactly 12 windows total; 5 windows emitted in FLUSH with din_ready=0.
REQ-025 win_ready toggled pseudo-randomly and din_valid gapped -> the 12 windows match the golden model in order; outputs hold while stalled.
REQ-026 Window (3,1) -> 3,4,0,7,8,0,11,12,0. Window (0,1) -> 0,1,2,0,5,6,0,9,10. Neither contains wrapped pixels.
REQ-027 Two back-to-back frames -> frame 2 window (0,0) = 0,0,0,0,1,2,0,5,6; no frame-1 pixels leak into frame 2.
REQ-028 rst pulsed after 7 acceptances, then a fresh frame -> outputs are at reset values during rst; the full 12-window frame is correct afterward.

Source files
------------

// File: rtl/line_window_3x3.sv
// line_window_3x3: streams a raster frame in and emits one 3x3 neighbourhood per pixel,
// in raster order of the window centre, with zeros for any tap outside the frame.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   din, din_valid/ready   pixel input stream, raster order
//   neighborhood           9 slots, slot k at [k*PIXEL_WIDTH +: PIXEL_WIDTH], row-major around centre
//   win_valid/ready        window output handshake
//   x_out, y_out           centre coordinate of the current window
//   win_last               current window is centred on the last pixel of the frame
// Frames are assumed to be at least 2 lines tall.
module line_window_3x3 #(
   parameter int unsigned WIDTH       = 320,
   parameter int unsigned HEIGHT      = 240,
   parameter int unsigned PIXEL_WIDTH = 24,
   localparam int unsigned XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
   localparam int unsigned YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [PIXEL_WIDTH-1:0]   din,
   input  logic                     din_valid,
   output logic                     din_ready,
   output logic [9*PIXEL_WIDTH-1:0] neighborhood,
   output logic                     win_valid,
   input  logic                     win_ready,
   output logic [XW-1:0]            x_out,
   output logic [YW-1:0]            y_out,
   output logic                     win_last
);

   localparam int unsigned PW = PIXEL_WIDTH;

   typedef enum logic [1:0] {S_FILL, S_RUN, S_FLUSH} state_t;

   state_t                  state_q;
   logic [XW-1:0]           ix_q;        // input column (keeps counting virtually in FLUSH)
   logic [YW-1:0]           iy_q;        // input row
   logic [XW-1:0]           nx_q;        // centre of the next window to load
   logic [YW-1:0]           ny_q;
   logic [PW-1:0]           raw_q [3][3];
   logic [PW-1:0]           raw_d [3][3];
   logic [PW-1:0]           lb0 [WIDTH]; // previous line
   logic [PW-1:0]           lb1 [WIDTH]; // line before that
   logic [9*PW-1:0]         nbr_d;
   logic [9*PW-1:0]         nbr_q;
   logic                    win_valid_q;
   logic                    win_last_q;
   logic [XW-1:0]           x_q;
   logic [YW-1:0]           y_q;

   logic                    slot_free;
   logic                    accept;
   logic                    flush_step;
   logic                    shift;
   logic                    load;
   logic                    last_d;
   logic                    last_out;
   logic [PW-1:0]           pix_in;
   logic [XW-1:0]           ix_inc;
   logic [YW-1:0]           iy_inc;
   logic [XW-1:0]           nx_inc;
   logic [YW-1:0]           ny_inc;

   assign neighborhood = nbr_q;
   assign win_valid    = win_valid_q;
   assign win_last     = win_last_q;
   assign x_out        = x_q;
   assign y_out        = y_q;

   // Handshake and step qualifiers
   always_comb begin
      slot_free  = !win_valid_q || win_ready;
      din_ready  = !rst && ((state_q == S_FILL) || ((state_q == S_RUN) && slot_free));
      accept     = din_valid && din_ready;
      last_out   = win_valid_q && win_last_q;
      // Once the last window is loaded, FLUSH only waits for it to be taken
      flush_step = (state_q == S_FLUSH) && slot_free && !last_out;
      shift      = accept || flush_step;
      load       = ((state_q == S_RUN) && accept) || flush_step;
      pix_in     = (state_q == S_FLUSH) ? '0 : din;
      last_d     = (nx_q == XW'(WIDTH - 1)) && (ny_q == YW'(HEIGHT - 1));
      ix_inc     = (ix_q == XW'(WIDTH - 1))  ? '0 : ix_q + XW'(1);
      iy_inc     = (iy_q == YW'(HEIGHT - 1)) ? '0 : iy_q + YW'(1);
      nx_inc     = (nx_q == XW'(WIDTH - 1))  ? '0 : nx_q + XW'(1);
      ny_inc     = (ny_q == YW'(HEIGHT - 1)) ? '0 : ny_q + YW'(1);
   end

   // Next raw window: shift left and bring in column ix from (row-2, row-1, row)
   always_comb begin
      for (int r = 0; r < 3; r++) begin
         raw_d[r][0] = raw_q[r][1];
         raw_d[r][1] = raw_q[r][2];
      end
      raw_d[0][2] = lb1[ix_q];
      raw_d[1][2] = lb0[ix_q];
      raw_d[2][2] = pix_in;
   end

   // Border masking for the window centred at (nx_q, ny_q); this also hides stale
   // line-buffer data and pixels wrapped in from the neighbouring row
   always_comb begin
      nbr_d = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            if (!((c == 0 && nx_q == '0) || (c == 2 && nx_q == XW'(WIDTH - 1)) ||
                  (r == 0 && ny_q == '0) || (r == 2 && ny_q == YW'(HEIGHT - 1)))) begin
               nbr_d[(r*3 + c)*PW +: PW] = raw_d[r][c];
            end
         end
      end
   end

   // Line buffers: no reset needed, masking and FILL cover stale contents
   always_ff @(posedge clk) begin
      if (shift) begin
         lb1[ix_q] <= lb0[ix_q];
         lb0[ix_q] <= pix_in;
      end
   end

   // Control FSM, counters, raw window and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_FILL;
         ix_q        <= '0;
         iy_q        <= '0;
         nx_q        <= '0;
         ny_q        <= '0;
         nbr_q       <= '0;
         win_valid_q <= 1'b0;
         win_last_q  <= 1'b0;
         x_q         <= '0;
         y_q         <= '0;
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               raw_q[r][c] <= '0;
            end
         end
      end else begin
         if (shift) begin
            raw_q <= raw_d;
            ix_q  <= ix_inc;
            if (ix_q == XW'(WIDTH - 1)) begin
               iy_q <= iy_inc;
            end
         end

         if (load) begin
            nbr_q       <= nbr_d;
            x_q         <= nx_q;
            y_q         <= ny_q;
            win_last_q  <= last_d;
            win_valid_q <= 1'b1;
            nx_q        <= nx_inc;
            if (nx_q == XW'(WIDTH - 1)) begin
               ny_q <= ny_inc;
            end
         end else if (win_ready) begin
            win_valid_q <= 1'b0;
         end

         case (state_q)
            S_FILL: begin
               // Acceptance of raster index WIDTH completes the fill
               if (accept && ix_q == '0 && iy_q == YW'(1)) begin
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               if (accept && ix_q == XW'(WIDTH - 1) && iy_q == YW'(HEIGHT - 1)) begin
                  state_q <= S_FLUSH;
               end
            end
            S_FLUSH: begin
               if (last_out && win_ready) begin
                  state_q     <= S_FILL;
                  ix_q        <= '0;
                  iy_q        <= '0;
                  nx_q        <= '0;
                  ny_q        <= '0;
                  win_valid_q <= 1'b0;
                  win_last_q  <= 1'b0;
               end
            end
            default: state_q <= S_FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_line_window_3x3.sv
// tb_line_window_3x3: directed bench for line_window_3x3 with WIDTH=4, HEIGHT=3,
// pixel value = raster index + 1 (+ optional frame offset).
module tb_line_window_3x3;

   localparam int unsigned W  = 4;
   localparam int unsigned H  = 3;
   localparam int unsigned PW = 8;
   localparam int unsigned NB = 9 * PW;

   logic          clk = 1'b0;
   logic          rst;
   logic [PW-1:0] din;
   logic          din_valid;
   logic          din_ready;
   logic [NB-1:0] neighborhood;
   logic          win_valid;
   logic          win_ready;
   logic [1:0]    x_out;
   logic [1:0]    y_out;
   logic          win_last;

   int            checks = 0;
   int            errors = 0;
   logic [NB-1:0] cap [12];

   line_window_3x3 #(.WIDTH(W), .HEIGHT(H), .PIXEL_WIDTH(PW)) dut (
      .clk          (clk),
      .rst          (rst),
      .din          (din),
      .din_valid    (din_valid),
      .din_ready    (din_ready),
      .neighborhood (neighborhood),
      .win_valid    (win_valid),
      .win_ready    (win_ready),
      .x_out        (x_out),
      .y_out        (y_out),
      .win_last     (win_last)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Golden window: slot k = pixel at (cx+k%3-1, cy+k/3-1), zero outside the frame
   function automatic logic [NB-1:0] exp_win(input int cx, input int cy, input int off);
      logic [NB-1:0] v;
      int x;
      int y;
      v = '0;
      for (int k = 0; k < 9; k++) begin
         x = cx + (k % 3) - 1;
         y = cy + (k / 3) - 1;
         if (x >= 0 && x < int'(W) && y >= 0 && y < int'(H)) begin
            v[k*PW +: PW] = PW'(off + y * int'(W) + x + 1);
         end
      end
      return v;
   endfunction

   // Streams one frame; mode 0 = continuous, mode 1 = gapped input and random win_ready
   task automatic run_frame(input int off, input int mode, input string nm);
      int sent;
      int got;
      int cyc;
      int acc6;
      int first_v;
      int nfl;
      logic pv;
      logic ptr;
      logic pdr;
      logic stalled;
      logic [NB-1:0] s_nb;
      logic [1:0] s_x;
      logic [1:0] s_y;
      logic s_l;
      sent = 0; got = 0; cyc = 0; acc6 = -1; first_v = -1; nfl = 0;
      pv = 1'b0; ptr = 1'b0; pdr = 1'b0; stalled = 1'b0;
      s_nb = '0; s_x = '0; s_y = '0; s_l = 1'b0;
      while (got < 12 && cyc < 400) begin
         @(negedge clk);
         if (mode == 0) begin
            din_valid = (sent < 12);
            win_ready = 1'b1;
         end else begin
            din_valid = (sent < 12) && ($urandom_range(0, 2) != 0);
            win_ready = ($urandom_range(0, 1) == 1);
         end
         din = PW'(off + sent + 1);
         #1;
         if (stalled) begin
            chk({nm, " hold_valid"}, NB'(win_valid), NB'(1));
            chk({nm, " hold_nbr"},   neighborhood, s_nb);
            chk({nm, " hold_xy"},    NB'({x_out, y_out, win_last}), NB'({s_x, s_y, s_l}));
         end
         if (win_valid && first_v < 0) first_v = cyc;
         // A window that appears after an edge where din_ready was low was built in FLUSH
         if (win_valid && (!pv || ptr) && !pdr) nfl++;
         if (win_valid && win_ready) begin
            chk($sformatf("%s win%0d_nbr", nm, got), neighborhood,
                exp_win(got % int'(W), got / int'(W), off));
            chk($sformatf("%s win%0d_x", nm, got), NB'(x_out), NB'(got % int'(W)));
            chk($sformatf("%s win%0d_y", nm, got), NB'(y_out), NB'(got / int'(W)));
            chk($sformatf("%s win%0d_last", nm, got), NB'(win_last), NB'(got == 11));
            cap[got] = neighborhood;
            got++;
         end
         stalled = win_valid && !win_ready;
         s_nb = neighborhood; s_x = x_out; s_y = y_out; s_l = win_last;
         pv  = win_valid;
         ptr = win_valid && win_ready;
         pdr = din_ready;
         if (din_valid && din_ready) begin
            sent++;
            if (sent == 6) acc6 = cyc;
         end
         cyc++;
      end
      din_valid = 1'b0;
      chk({nm, " windows_before_timeout"}, NB'(got), NB'(12));
      chk({nm, " pixels_accepted"}, NB'(sent), NB'(12));
      chk({nm, " flush_windows"}, NB'(nfl), NB'(5));
      if (mode == 0) begin
         chk({nm, " first_valid_cycle"}, NB'(first_v), NB'(acc6 + 1));
      end
   endtask

   initial begin
      int n;
      rst = 1'b1; din = '0; din_valid = 1'b0; win_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_outputs", NB'({din_ready, win_valid, win_last, x_out, y_out}), NB'(0));
      chk("reset_nbr", neighborhood, NB'(0));
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("ready_after_reset", NB'(din_ready), NB'(1));

      // Continuous stream
      run_frame(0, 0, "cont");
      chk("cont_win00",   cap[0],  72'h06_05_00_02_01_00_00_00_00);
      chk("cont_win01_y", cap[4],  72'h0a_09_00_06_05_00_02_01_00);
      chk("cont_win31",   cap[7],  72'h00_0c_0b_00_08_07_00_04_03);
      chk("cont_win32",   cap[11], 72'h00_00_00_00_0c_0b_00_08_07);

      // Gapped input and random back-pressure
      run_frame(0, 1, "stall");

      // Back-to-back frames with distinct values; frame 2 must not see frame 1
      run_frame(100, 0, "frameA");
      run_frame(0, 0, "frameB");
      chk("frameB_win00", cap[0], 72'h06_05_00_02_01_00_00_00_00);

      // Mid-frame reset after 7 acceptances
      n = 0;
      win_ready = 1'b1;
      for (int c = 0; c < 50 && n < 7; c++) begin
         @(negedge clk);
         din_valid = 1'b1;
         din = PW'(200 + n);
         #1;
         if (din_ready) n++;
      end
      @(negedge clk);
      din_valid = 1'b0;
      chk("pre_reset_accepts", NB'(n), NB'(7));
      rst = 1'b1;
      #1;
      chk("midreset_outputs", NB'({din_ready, win_valid, win_last, x_out, y_out}), NB'(0));
      chk("midreset_nbr", neighborhood, NB'(0));
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midreset_ready", NB'(din_ready), NB'(1));
      run_frame(0, 0, "postrst");
      chk("postrst_win00", cap[0], 72'h06_05_00_02_01_00_00_00_00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
